// File: rtl/next_pc_unit.sv
// -----------------------------------------------------------------------------
// next_pc_unit
//
// Program-counter and flow-control unit. It owns the PC and resolves the
// flow code {status2,status1,status0} from the control decoder.
// Register-indirect and PC-relative branches resolve in a single cycle.
// Memory-indirect jumps (bmn, jmor, jalm, jspal) issue a data-memory read
// and stall the core until the read data (the jump target) returns.
// jalm and jspal also strobe a link value (pc+4) towards r31.
//
// Optional feature, macro NPC_MISALIGN_TRAP_EN:
//   defined   -> a resolved target with target[1:0] != 0 loads TRAP_VECTOR
//                instead and pulses trap for one cycle.
//   undefined -> targets are loaded unchanged and trap stays 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid           current instruction may retire this cycle
//   status[2:0]           flow code from the control decoder
//   rs_val, sp_val        rs operand and r29 (jspal base)
//   imm[15:0]             instruction immediate
//   alu_zero              ALU zero output (beq condition)
//   flag_we, alu_result   latch N/Z flags from alu_result
//   mem_req, mem_addr     memory read request/address, held until acknowledged
//   mem_ack, mem_rdata    read data valid strobe and data (jump target)
//   pc                    current PC
//   stall                 core must hold the current instruction
//   link_we, link_data    one-cycle r31 write strobe and value
//   trap                  one-cycle misalignment trap pulse
// -----------------------------------------------------------------------------
module next_pc_unit #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = 32'h0000_0080
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [2:0]        status,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [ADDR_W-1:0] sp_val,
  input  logic [15:0]       imm,
  input  logic              alu_zero,
  input  logic              flag_we,
  input  logic [ADDR_W-1:0] alu_result,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              stall,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic              trap
);

  typedef enum logic {
    RUN,
    MEMWAIT
  } state_t;

  state_t state;
  logic   n_flag;
  logic   z_flag;

  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] sext_imm;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] run_target;
  logic [ADDR_W-1:0] mem_target;
  logic              run_redirect;
  logic              run_issue;
  logic              run_link;
  logic              run_bad;
  logic              ack_bad;

  assign seq       = pc + ADDR_W'(4);
  assign sext_imm  = {{(ADDR_W-16){imm[15]}}, imm};
  assign br_target = seq + (sext_imm << 2);

  // Decode of the flow code while running. run_redirect marks a taken
  // single-cycle target (subject to the alignment check); run_issue marks
  // a memory-indirect jump that must go through MEMWAIT.
  always_comb begin
    run_target   = seq;
    mem_target   = rs_val;
    run_redirect = 1'b0;
    run_issue    = 1'b0;
    run_link     = 1'b0;
    case (status)
      3'b000: run_target = seq;
      3'b111: begin
        if (alu_zero) begin
          run_target   = br_target;
          run_redirect = 1'b1;
        end
      end
      3'b011: begin
        if (z_flag) begin
          run_target   = br_target;
          run_redirect = 1'b1;
        end
      end
      3'b010: begin
        if (z_flag) begin
          run_target   = rs_val;
          run_redirect = 1'b1;
        end
      end
      3'b001: begin
        if (n_flag) begin
          run_issue  = 1'b1;
          mem_target = rs_val + sext_imm;
        end
      end
      3'b100: begin
        run_issue  = 1'b1;
        mem_target = rs_val;
      end
      3'b101: begin
        run_issue  = 1'b1;
        run_link   = 1'b1;
        mem_target = rs_val + sext_imm;
      end
      3'b110: begin
        run_issue  = 1'b1;
        run_link   = 1'b1;
        mem_target = sp_val;
      end
    endcase
  end

`ifdef NPC_MISALIGN_TRAP_EN
  assign run_bad = run_redirect && (run_target[1:0] != 2'b00);
  assign ack_bad = (mem_rdata[1:0] != 2'b00);
`else
  assign run_bad = 1'b0;
  assign ack_bad = 1'b0;
`endif

  // The core is held for every cycle spent waiting on the read.
  assign stall = (state == MEMWAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= RESET_PC;
      n_flag    <= 1'b0;
      z_flag    <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      link_we   <= 1'b0;
      link_data <= '0;
      trap      <= 1'b0;
    end else begin
      link_we <= 1'b0;
      trap    <= 1'b0;
      // Branches above used the old flags; the update is seen from the
      // next instruction on.
      if (flag_we) begin
        z_flag <= (alu_result == '0);
        n_flag <= alu_result[ADDR_W-1];
      end
      case (state)
        RUN: begin
          if (instr_valid) begin
            if (run_issue) begin
              // pc keeps pointing at the jump until the target arrives,
              // but the link value is committed right away.
              state    <= MEMWAIT;
              mem_req  <= 1'b1;
              mem_addr <= mem_target;
              if (run_link) begin
                link_we   <= 1'b1;
                link_data <= seq;
              end
            end else begin
              pc   <= run_bad ? TRAP_VECTOR : run_target;
              trap <= run_bad;
            end
          end
        end
        MEMWAIT: begin
          if (mem_ack) begin
            pc      <= ack_bad ? TRAP_VECTOR : mem_rdata;
            trap    <= ack_bad;
            mem_req <= 1'b0;
            state   <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_next_pc_unit
//
// Scoreboard bench for next_pc_unit. The driver applies one stimulus vector
// per clock (on the falling edge), advances a behavioural reference model and
// pushes the expected post-edge outputs into a queue. An independent monitor
// pops one entry after every rising edge and compares it with the DUT.
// Directed sequences walk through the documented scenarios, then randomized
// vectors exercise the remaining combinations.
// -----------------------------------------------------------------------------
module tb_next_pc_unit;

  localparam int          AW      = 32;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC = 32'h0000_0080;

  typedef struct packed {
    logic        rst_n;
    logic        instr_valid;
    logic [2:0]  status;
    logic [31:0] rs_val;
    logic [31:0] sp_val;
    logic [15:0] imm;
    logic        alu_zero;
    logic        flag_we;
    logic [31:0] alu_result;
    logic        mem_ack;
    logic [31:0] mem_rdata;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        link_we;
    logic [31:0] link_data;
    logic        trap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [2:0]  status;
  logic [31:0] rs_val;
  logic [31:0] sp_val;
  logic [15:0] imm;
  logic        alu_zero;
  logic        flag_we;
  logic [31:0] alu_result;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic        stall;
  logic        link_we;
  logic [31:0] link_data;
  logic        trap;

  int n_vectors     = 0;
  int n_miscompares = 0;

  exp_t sb_q[$];

  // Reference model state: the architectural view of the unit.
  logic [31:0] m_pc;
  logic        m_n;
  logic        m_z;
  logic        m_wait;
  logic [31:0] m_addr;
  logic        m_link_we;
  logic [31:0] m_link_data;
  logic        m_trap;

  next_pc_unit #(
    .ADDR_W     (AW),
    .RESET_PC   (RST_PC),
    .TRAP_VECTOR(TRAP_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .status     (status),
    .rs_val     (rs_val),
    .sp_val     (sp_val),
    .imm        (imm),
    .alu_zero   (alu_zero),
    .flag_we    (flag_we),
    .alu_result (alu_result),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .pc         (pc),
    .stall      (stall),
    .link_we    (link_we),
    .link_data  (link_data),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Target load with optional alignment trap.
  task automatic modelLoad(input logic [31:0] target);
`ifdef NPC_MISALIGN_TRAP_EN
    if (target[1:0] != 2'b00) begin
      m_pc   = TRAP_PC;
      m_trap = 1'b1;
    end else begin
      m_pc = target;
    end
`else
    m_pc = target;
`endif
  endtask

  task automatic modelIssue(input logic [31:0] addr, input bit link,
                            input logic [31:0] seq);
    m_wait = 1'b1;
    m_addr = addr;
    if (link) begin
      m_link_we   = 1'b1;
      m_link_data = seq;
    end
  endtask

  task automatic modelStep(input stim_t s);
    logic [31:0] seq;
    logic [31:0] simm;
    logic [31:0] rel;
    exp_t        e;
    m_link_we = 1'b0;
    m_trap    = 1'b0;
    if (!s.rst_n) begin
      m_pc        = RST_PC;
      m_n         = 1'b0;
      m_z         = 1'b0;
      m_wait      = 1'b0;
      m_addr      = 32'h0;
      m_link_data = 32'h0;
    end else begin
      simm = 32'($signed(s.imm));
      seq  = m_pc + 32'd4;
      rel  = seq + simm * 32'd4;
      if (m_wait) begin
        if (s.mem_ack) begin
          m_wait = 1'b0;
          modelLoad(s.mem_rdata);
        end
      end else if (s.instr_valid) begin
        case (s.status)
          3'b000: m_pc = seq;
          3'b111: if (s.alu_zero) modelLoad(rel); else m_pc = seq;
          3'b011: if (m_z) modelLoad(rel); else m_pc = seq;
          3'b010: if (m_z) modelLoad(s.rs_val); else m_pc = seq;
          3'b001: if (m_n) modelIssue(s.rs_val + simm, 1'b0, seq); else m_pc = seq;
          3'b100: modelIssue(s.rs_val, 1'b0, seq);
          3'b101: modelIssue(s.rs_val + simm, 1'b1, seq);
          3'b110: modelIssue(s.sp_val, 1'b1, seq);
        endcase
      end
      if (s.flag_we) begin
        m_z = (s.alu_result == 32'h0);
        m_n = s.alu_result[31];
      end
    end
    e.pc        = m_pc;
    e.stall     = m_wait;
    e.mem_req   = m_wait;
    e.mem_addr  = m_addr;
    e.link_we   = m_link_we;
    e.link_data = m_link_data;
    e.trap      = m_trap;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    rst_n       = s.rst_n;
    instr_valid = s.instr_valid;
    status      = s.status;
    rs_val      = s.rs_val;
    sp_val      = s.sp_val;
    imm         = s.imm;
    alu_zero    = s.alu_zero;
    flag_we     = s.flag_we;
    alu_result  = s.alu_result;
    mem_ack     = s.mem_ack;
    mem_rdata   = s.mem_rdata;
    modelStep(s);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s       = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t flowStim(input logic [2:0] code);
    stim_t s;
    s             = idleStim();
    s.instr_valid = 1'b1;
    s.status      = code;
    return s;
  endfunction

  function automatic logic [31:0] mostlyAligned();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(3) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rst_n       = ($urandom_range(199) != 0);
    s.instr_valid = ($urandom_range(4) != 0);
    s.status      = 3'($urandom_range(7));
    s.rs_val      = mostlyAligned();
    s.sp_val      = mostlyAligned();
    s.imm         = 16'($urandom);
    s.alu_zero    = 1'($urandom_range(1));
    s.flag_we     = ($urandom_range(9) < 3);
    s.alu_result  = ($urandom_range(3) == 0) ? 32'h0 : 32'($urandom);
    s.mem_ack     = ($urandom_range(9) < 4);
    s.mem_rdata   = mostlyAligned();
    return s;
  endfunction

  // Monitor: one expected entry per rising edge, sampled 1 time unit after it.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput("sb_pc", pc, e.pc);
      checkOutput("sb_stall", 32'(stall), 32'(e.stall));
      checkOutput("sb_mem_req", 32'(mem_req), 32'(e.mem_req));
      checkOutput("sb_link_we", 32'(link_we), 32'(e.link_we));
      checkOutput("sb_trap", 32'(trap), 32'(e.trap));
      if (e.mem_req) checkOutput("sb_mem_addr", mem_addr, e.mem_addr);
      if (e.link_we) checkOutput("sb_link_data", link_data, e.link_data);
    end
  end

  initial begin : driver
    stim_t s;
    rst_n = 1'b0; instr_valid = 1'b0; status = 3'b000; rs_val = '0;
    sp_val = '0; imm = '0; alu_zero = 1'b0; flag_we = 1'b0;
    alu_result = '0; mem_ack = 1'b0; mem_rdata = '0;
    s = idleStim();
    s.rst_n = 1'b0;
    modelStep(s);
    void'(sb_q.pop_back());
    #1;
    checkOutput("reset_pc", pc, RST_PC);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_link_we", 32'(link_we), 32'd0);
    checkOutput("reset_trap", 32'(trap), 32'd0);
    repeat (2) applyStimulus(s);

    // Sequential flow after reset.
    applyStimulus(flowStim(3'b000)); settle(); checkOutput("seq_pc1", pc, 32'h4);
    applyStimulus(flowStim(3'b000)); settle(); checkOutput("seq_pc2", pc, 32'h8);
    applyStimulus(flowStim(3'b000)); settle(); checkOutput("seq_pc3", pc, 32'hC);
    checkOutput("seq_stall", 32'(stall), 32'd0);
    applyStimulus(flowStim(3'b000)); settle(); checkOutput("seq_pc4", pc, 32'h10);

    // bz with Z set, then with Z clear.
    s = idleStim(); s.flag_we = 1'b1; s.alu_result = 32'h0; applyStimulus(s);
    s = flowStim(3'b011); s.imm = 16'd3; applyStimulus(s);
    settle(); checkOutput("bz_taken_pc", pc, 32'h20);
    s = idleStim(); s.flag_we = 1'b1; s.alu_result = 32'h5; applyStimulus(s);
    s = flowStim(3'b011); s.imm = 16'd3; applyStimulus(s);
    settle(); checkOutput("bz_not_taken_pc", pc, 32'h24);

    // beq to 0x40, then jalm with three wait cycles.
    s = flowStim(3'b111); s.alu_zero = 1'b1; s.imm = 16'd6; applyStimulus(s);
    settle(); checkOutput("beq_pc", pc, 32'h40);
    s = flowStim(3'b101); s.rs_val = 32'h100; s.imm = 16'd8; applyStimulus(s);
    settle();
    checkOutput("jalm_mem_addr", mem_addr, 32'h108);
    checkOutput("jalm_link_we", 32'(link_we), 32'd1);
    checkOutput("jalm_link_data", link_data, 32'h44);
    checkOutput("jalm_pc_hold", pc, 32'h40);
    s = flowStim(3'b000); applyStimulus(s);
    settle(); checkOutput("jalm_wait_stall", 32'(stall), 32'd1);
    checkOutput("jalm_link_pulse_end", 32'(link_we), 32'd0);
    applyStimulus(s);
    s.mem_ack = 1'b1; s.mem_rdata = 32'h400; applyStimulus(s);
    settle();
    checkOutput("jalm_target_pc", pc, 32'h400);
    checkOutput("jalm_req_drop", 32'(mem_req), 32'd0);

    // bmn uses the old N flag, the next bmn sees the new one.
    s = flowStim(3'b001); s.flag_we = 1'b1; s.alu_result = 32'h8000_0000;
    s.rs_val = 32'h300; s.imm = 16'd4; applyStimulus(s);
    settle();
    checkOutput("bmn_not_taken_pc", pc, 32'h404);
    checkOutput("bmn_not_taken_req", 32'(mem_req), 32'd0);
    s.flag_we = 1'b0; applyStimulus(s);
    settle();
    checkOutput("bmn_taken_req", 32'(mem_req), 32'd1);
    checkOutput("bmn_taken_addr", mem_addr, 32'h304);
    s = idleStim(); s.mem_ack = 1'b1; s.mem_rdata = 32'h500; applyStimulus(s);
    settle(); checkOutput("bmn_target_pc", pc, 32'h500);

    // jspal aborted by reset during MEMWAIT.
    s = flowStim(3'b110); s.sp_val = 32'h200; applyStimulus(s);
    settle();
    checkOutput("jspal_mem_addr", mem_addr, 32'h200);
    checkOutput("jspal_link_data", link_data, 32'h504);
    s = idleStim(); s.rst_n = 1'b0; s.mem_ack = 1'b1; s.mem_rdata = 32'h700;
    applyStimulus(s);
    #1;
    checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
    checkOutput("abort_stall", 32'(stall), 32'd0);
    checkOutput("abort_link_we", 32'(link_we), 32'd0);
    checkOutput("abort_pc", pc, RST_PC);
    s.rst_n = 1'b1; applyStimulus(s);
    settle();
    checkOutput("late_ack_pc", pc, RST_PC);
    checkOutput("late_ack_req", 32'(mem_req), 32'd0);

    // brz to a misaligned register target.
    s = idleStim(); s.flag_we = 1'b1; s.alu_result = 32'h0; applyStimulus(s);
    s = flowStim(3'b010); s.rs_val = 32'h102; applyStimulus(s);
    settle();
`ifdef NPC_MISALIGN_TRAP_EN
    checkOutput("brz_misalign_pc", pc, TRAP_PC);
    checkOutput("brz_misalign_trap", 32'(trap), 32'd1);
`else
    checkOutput("brz_misalign_pc", pc, 32'h102);
    checkOutput("brz_misalign_trap", 32'(trap), 32'd0);
`endif
    applyStimulus(idleStim());
    settle(); checkOutput("trap_pulse_end", 32'(trap), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) applyStimulus(randStim());

    applyStimulus(idleStim());
    repeat (2) @(posedge clk);
    #3;
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
